// File: rtl/cv32e40n_apu_requester.sv
// -----------------------------------------------------------------------------
// cv32e40n_apu_requester
//
// Initiator side of the APU request/response protocol. Core-side commands
// arrive on a valid/ready port, are held and presented on the APU req/gnt
// channel, and their tags are queued until the in-order rvalid response comes
// back. Responses cannot be backpressured, so they land in a result FIFO whose
// space is reserved up front by a credit check at command accept.
//
// Optional feature: define APU_REQ_TIMEOUT_EN to build the watchdog that sets
// timeout_o after TIMEOUT_CYCLES cycles without grant/response progress.
// Without the macro timeout_o is tied to 0.
//
// Ports
//   clk_i, rst_i          clock, asynchronous active-high reset
//   cmd_*                 command port (valid/ready), operands/op/flags/tag
//   apu_req_o, apu_gnt_i  APU request channel, apu_operands_o/op_o/flags_o held
//   apu_rvalid_i          APU response strobe with apu_result_i/apu_flags_i
//   res_*                 result port (valid/ready), data/flags/tag
//   busy_o                any operation held, outstanding or buffered
//   err_o                 sticky: response arrived with nothing outstanding
//   timeout_o             sticky watchdog flag
// -----------------------------------------------------------------------------

package cv32e40p_apu_core_pkg;
    parameter int APU_NARGS_CPU    = 3;
    parameter int APU_WOP_CPU      = 6;
    parameter int APU_NDSFLAGS_CPU = 15;
    parameter int APU_NUSFLAGS_CPU = 5;
endpackage

module cv32e40n_apu_requester
    import cv32e40p_apu_core_pkg::*;
#(
    parameter int DEPTH          = 4,
    parameter int TAG_W          = 4,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                              clk_i,
    input  logic                              rst_i,

    input  logic                              cmd_valid_i,
    output logic                              cmd_ready_o,
    input  logic [APU_NARGS_CPU-1:0][31:0]    cmd_operands_i,
    input  logic [APU_WOP_CPU-1:0]            cmd_op_i,
    input  logic [APU_NDSFLAGS_CPU-1:0]       cmd_flags_i,
    input  logic [TAG_W-1:0]                  cmd_tag_i,

    output logic                              apu_req_o,
    input  logic                              apu_gnt_i,
    output logic [APU_NARGS_CPU-1:0][31:0]    apu_operands_o,
    output logic [APU_WOP_CPU-1:0]            apu_op_o,
    output logic [APU_NDSFLAGS_CPU-1:0]       apu_flags_o,

    input  logic                              apu_rvalid_i,
    input  logic [31:0]                       apu_result_i,
    input  logic [APU_NUSFLAGS_CPU-1:0]       apu_flags_i,

    output logic                              res_valid_o,
    input  logic                              res_ready_i,
    output logic [31:0]                       res_data_o,
    output logic [APU_NUSFLAGS_CPU-1:0]       res_flags_o,
    output logic [TAG_W-1:0]                  res_tag_o,

    output logic                              busy_o,
    output logic                              err_o,
    output logic                              timeout_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_e;

    typedef struct packed {
        logic [31:0]                 data;
        logic [APU_NUSFLAGS_CPU-1:0] flags;
        logic [TAG_W-1:0]            tag;
    } res_entry_t;

    state_e                           state_q;
    logic [APU_NARGS_CPU-1:0][31:0]   hold_operands_q;
    logic [APU_WOP_CPU-1:0]           hold_op_q;
    logic [APU_NDSFLAGS_CPU-1:0]      hold_flags_q;
    logic [TAG_W-1:0]                 hold_tag_q;

    logic [CW-1:0]                    outst_q, outst_d;
    logic [CW-1:0]                    res_cnt_q, res_cnt_d;
    logic [PW-1:0]                    tag_wr_q, tag_rd_q;
    logic [PW-1:0]                    res_wr_q, res_rd_q;
    logic [TAG_W-1:0]                 tag_mem [DEPTH];
    res_entry_t                       res_mem [DEPTH];
    res_entry_t                       res_head;
    logic                             err_q;

    logic [CW:0]                      total;
    logic                             credit_ok;
    logic                             in_req;
    logic                             grant;
    logic                             accept;
    logic                             cmd_ready_int;
    logic                             resp_ok;
    logic                             resp_err;
    logic                             res_pop;

    assign in_req    = (state_q == REQ);
    // A same-cycle result pop is deliberately not credited here.
    assign total     = {{CW{1'b0}}, in_req} + {1'b0, outst_q} + {1'b0, res_cnt_q};
    assign credit_ok = (total < (CW+1)'(DEPTH));

    assign grant         = in_req & apu_gnt_i;
    assign cmd_ready_int = in_req ? (apu_gnt_i & credit_ok) : credit_ok;
    assign accept        = cmd_valid_i & cmd_ready_int;

    // A response is only legal against a grant from an earlier cycle.
    assign resp_ok  = apu_rvalid_i & (outst_q != '0);
    assign resp_err = apu_rvalid_i & (outst_q == '0);
    assign res_pop  = (res_cnt_q != '0) & res_ready_i;

    // state | meaning
    // IDLE  | no request held; accept when credit allows
    // REQ   | hold registers driven with apu_req_o=1 until granted
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q         <= IDLE;
            hold_operands_q <= '0;
            hold_op_q       <= '0;
            hold_flags_q    <= '0;
            hold_tag_q      <= '0;
        end else begin
            if (accept) begin
                hold_operands_q <= cmd_operands_i;
                hold_op_q       <= cmd_op_i;
                hold_flags_q    <= cmd_flags_i;
                hold_tag_q      <= cmd_tag_i;
                state_q         <= REQ;
            end else if (grant) begin
                state_q         <= IDLE;
            end
        end
    end

    always_comb begin
        outst_d = outst_q;
        case ({grant, resp_ok})
            2'b10:   outst_d = outst_q + CW'(1);
            2'b01:   outst_d = outst_q - CW'(1);
            default: outst_d = outst_q;
        endcase
    end

    always_comb begin
        res_cnt_d = res_cnt_q;
        case ({resp_ok, res_pop})
            2'b10:   res_cnt_d = res_cnt_q + CW'(1);
            2'b01:   res_cnt_d = res_cnt_q - CW'(1);
            default: res_cnt_d = res_cnt_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            outst_q   <= '0;
            res_cnt_q <= '0;
            tag_wr_q  <= '0;
            tag_rd_q  <= '0;
            res_wr_q  <= '0;
            res_rd_q  <= '0;
            err_q     <= 1'b0;
        end else begin
            outst_q   <= outst_d;
            res_cnt_q <= res_cnt_d;
            if (grant)   tag_wr_q <= tag_wr_q + PW'(1);
            if (resp_ok) tag_rd_q <= tag_rd_q + PW'(1);
            if (resp_ok) res_wr_q <= res_wr_q + PW'(1);
            if (res_pop) res_rd_q <= res_rd_q + PW'(1);
            if (resp_err) err_q <= 1'b1;
        end
    end

    // Storage needs no reset: occupancy is tracked by the counters above.
    always_ff @(posedge clk_i) begin
        if (grant) begin
            tag_mem[tag_wr_q] <= hold_tag_q;
        end
        if (resp_ok) begin
            res_mem[res_wr_q] <= '{data: apu_result_i, flags: apu_flags_i, tag: tag_mem[tag_rd_q]};
        end
    end

    assign res_head = res_mem[res_rd_q];

    assign cmd_ready_o    = cmd_ready_int & ~rst_i;
    assign apu_req_o      = in_req;
    assign apu_operands_o = hold_operands_q;
    assign apu_op_o       = hold_op_q;
    assign apu_flags_o    = hold_flags_q;

    assign res_valid_o    = (res_cnt_q != '0);
    assign res_data_o     = res_valid_o ? res_head.data  : '0;
    assign res_flags_o    = res_valid_o ? res_head.flags : '0;
    assign res_tag_o      = res_valid_o ? res_head.tag   : '0;

    assign busy_o         = (total != '0);
    assign err_o          = err_q;

`ifdef APU_REQ_TIMEOUT_EN
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);

    logic [WW-1:0] wd_q;
    logic          timeout_q;
    logic          wd_wait;

    assign wd_wait = (in_req & ~apu_gnt_i) | ((outst_q != '0) & ~apu_rvalid_i);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wd_q      <= '0;
            timeout_q <= 1'b0;
        end else if (apu_gnt_i | apu_rvalid_i) begin
            wd_q      <= '0;
        end else if (wd_wait) begin
            if (wd_q != WW'(TIMEOUT_CYCLES)) wd_q <= wd_q + WW'(1);
            if (wd_q == WW'(TIMEOUT_CYCLES - 1)) timeout_q <= 1'b1;
        end
    end

    assign timeout_o = timeout_q;
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
    assign timeout_o = 1'b0;
`endif

endmodule
